scene_recover: RTL and testbench
================================

SCENE_RECOVER -- requirements
Module: scene_recover

Interface
REQ-001 Parameter OMEGA_Q8, default 243, haze-retention factor in Q0.8 (243 = 0.95).
REQ-002 Parameter T0, default 26, lower clamp on 8-bit transmission; SHALL be 1..255.
REQ-003 clk  input  1  clock, all state on rising edge.
REQ-004 reset  input  1  reset, asynchronous, active-high.
REQ-005 a_load  input  1  one-cycle strobe; latches atmospheric light.
REQ-006 a_r, a_g, a_b  input  8 each  atmospheric light A per channel, sampled when a_load=1.
REQ-007 in_valid  input  1  pixel offered.
REQ-008 in_ready  output  1  block can accept a pixel.
REQ-009 in_r, in_g, in_b  input  8 each  hazy centre pixel I.
REQ-010 in_dark  input  8  dark channel of the pixel's 3x3 window, raw minimum, not normalised.
REQ-011 in_last  input  1  last pixel of frame tag.
REQ-012 out_valid  output  1  recovered pixel available.
REQ-013 out_ready  input  1  downstream accepts.
REQ-014 out_r, out_g, out_b  output  8 each  recovered radiance J.
REQ-015 out_t  output  8  transmission used, 255 = 1.0.
REQ-016 out_last  output  1  in_last of the same pixel.

Function
REQ-017 A shadow registers SHALL load a_r/a_g/a_b on any edge with a_load=1, in any state.
REQ-018 Acceptance SHALL occur on an edge with in_valid=1 and in_ready=1; pixel, dark, last and A are snapshotted into working registers there.
REQ-019 If a_load and acceptance share an edge, the accepted pixel SHALL use the newly loaded A (bypass).
REQ-020 in_ready SHALL be 1 only in state IDLE and reset deasserted; it SHALL be combinational from state.
REQ-021 States: IDLE -> DIV_T (accept) -> DIV_R -> DIV_G -> DIV_B -> OUT -> IDLE (out handshake).
REQ-022 Each DIV state SHALL take exactly 17 cycles: 1 operand setup and 16 restoring-divider iterations on a single shared 16-bit by 8-bit unsigned divider with a 16-bit quotient.
REQ-023 out_valid SHALL rise after the 68th rising edge following the acceptance edge; latency is fixed and data-independent.
REQ-024 A_min = min(A_r, A_g, A_b) of the snapshot.
REQ-025 DIV_T: norm = min(255, floor(dark*255 / A_min)); if A_min = 0, norm = 255 and the state still lasts 17 cycles.
REQ-026 haze = (norm*OMEGA_Q8) >> 8, truncated; t = max(255 - haze, T0).
REQ-027 DIV_c for c in {R, G, B}: d = I_c - A_c (signed 9-bit); q = floor(|d|*255 / t).
REQ-028 J_c = A_c + q if d >= 0, else A_c - q; saturate to 0..255. No wrap is permitted, including when q exceeds 8 bits.
REQ-029 In OUT: out_valid=1; out_r/g/b/t/last SHALL hold stable until out_ready=1.
REQ-030 An out handshake SHALL return the block to IDLE on the next edge, so in_ready reasserts one cycle later; minimum pitch is 70 cycles per pixel.
REQ-031 out_* data SHALL retain the last value outside OUT; only out_valid qualifies the data.
REQ-032 in_valid during non-IDLE states SHALL be ignored; the upstream holds the pixel per the valid/ready rule.

Reset
REQ-033 On reset=1: state = IDLE, out_valid = 0, out_r/g/b/t = 0, out_last = 0, A shadow = 255/255/255, working registers cleared. This SHALL take effect immediately and asynchronously.
REQ-034 Reset mid-operation SHALL discard the in-flight pixel; no output is ever produced for it.
REQ-035 After reset deassertion, in_ready SHALL be 1 in the first cycle.

Verification
REQ-036 a_load A=(200,200,200); pixel I=(100,150,250), dark=0 -> out=(100,150,250), out_t=255, 68 edges after accept.
REQ-037 a_load A=(200,180,220); pixel I=(210,170,230), dark=180 -> norm 255, haze 242, t clamped to 26, out=(255,82,255), out_t=26.
REQ-038 a_load A=(0,50,50); I=(0,60,40), dark=10 -> A_min=0 path, t=26. out=(0,148,0) (g: 50+98; b: 50-98 saturates to 0). Latency is still 68.
REQ-039 Backpressure: hold out_ready=0 for 10 cycles in OUT -> outputs stable, in_ready=0 throughout. Then out_ready=1 -> out_valid=0 and in_ready=1 on the following cycle.
REQ-040 Assert reset 30 cycles after accept -> out_valid=0, outputs 0, no result emitted; next pixel processes normally with A=255/255/255 unless reloaded.
REQ-041 a_load A=(100,100,100) on the same edge as acceptance of I=(50,50,50), dark=0, previous A=(200,200,200) -> out=(50,50,50), computed with the new A.

Source files
------------

// File: rtl/scene_recover.sv
// Dark-channel-prior scene radiance recovery for one pixel at a time on a shared 16/8 restoring divider.
// The output appears 68 cycles after the input is accepted; in_ready stays low until the result is taken.
module scene_recover #(
  parameter int unsigned OMEGA_Q8 = 243,
  parameter int unsigned T0       = 26
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       a_load,
  input  logic [7:0] a_r,
  input  logic [7:0] a_g,
  input  logic [7:0] a_b,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_r,
  input  logic [7:0] in_g,
  input  logic [7:0] in_b,
  input  logic [7:0] in_dark,
  input  logic       in_last,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_r,
  output logic [7:0] out_g,
  output logic [7:0] out_b,
  output logic [7:0] out_t,
  output logic       out_last
);

  typedef enum logic [2:0] {
    S_IDLE, S_DIV_T, S_DIV_R, S_DIV_G, S_DIV_B, S_OUT
  } state_t;

  localparam logic [7:0]  T0_L    = 8'(T0);
  localparam logic [15:0] OMEGA_W = 16'(OMEGA_Q8);

  state_t state_q, state_d;

  logic [7:0]  sh_r_q, sh_g_q, sh_b_q;
  logic [7:0]  ar_q, ag_q, ab_q;
  logic [7:0]  pr_q, pg_q, pb_q;
  logic [7:0]  dark_q;
  logic        last_q;
  logic [7:0]  t_q, jr_q, jg_q;
  logic [4:0]  cnt_q;
  logic [7:0]  rem_q, dvs_q;
  logic [15:0] quo_q;

  logic        accept, in_div, div_last;
  logic [7:0]  a_min, pix_c, a_c, mag;
  logic        neg;
  logic [15:0] dividend;
  logic [7:0]  divisor;
  logic [8:0]  rem_sh;
  logic        ge;
  logic [7:0]  rem_nx;
  logic [15:0] quo_nx;
  logic [7:0]  norm, haze, t_raw, t_new, j_new;
  logic [15:0] prod;
  logic [8:0]  sum;
  logic        q_big;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept)    state_d = S_DIV_T;
      S_DIV_T: if (div_last)  state_d = S_DIV_R;
      S_DIV_R: if (div_last)  state_d = S_DIV_G;
      S_DIV_G: if (div_last)  state_d = S_DIV_B;
      S_DIV_B: if (div_last)  state_d = S_OUT;
      S_OUT:   if (out_ready) state_d = S_IDLE;
      default:                state_d = S_IDLE;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    in_ready  = (state_q == S_IDLE) && !reset;
    out_valid = (state_q == S_OUT);
  end

  assign accept   = in_valid && in_ready;
  assign in_div   = (state_q == S_DIV_T) || (state_q == S_DIV_R) ||
                    (state_q == S_DIV_G) || (state_q == S_DIV_B);
  assign div_last = in_div && (cnt_q == 5'd16);

  always_comb begin
    a_min = ar_q;
    if (ag_q < a_min) a_min = ag_q;
    if (ab_q < a_min) a_min = ab_q;
  end

  always_comb begin
    pix_c = pr_q;
    a_c   = ar_q;
    case (state_q)
      S_DIV_G: begin pix_c = pg_q; a_c = ag_q; end
      S_DIV_B: begin pix_c = pb_q; a_c = ab_q; end
      default: begin pix_c = pr_q; a_c = ar_q; end
    endcase
  end

  assign neg = pix_c < a_c;
  assign mag = neg ? (a_c - pix_c) : (pix_c - a_c);

  assign dividend = (state_q == S_DIV_T) ? ({8'd0, dark_q} * 16'd255) : ({8'd0, mag} * 16'd255);
  assign divisor  = (state_q == S_DIV_T) ? a_min : t_q;

  // One restoring step; the remainder never exceeds the 8-bit divisor
  assign rem_sh = {rem_q, quo_q[15]};
  assign ge     = rem_sh >= {1'b0, dvs_q};
  assign rem_nx = ge ? 8'(rem_sh - {1'b0, dvs_q}) : rem_sh[7:0];
  assign quo_nx = {quo_q[14:0], ge};
  assign q_big  = |quo_nx[15:8];

  always_comb begin
    norm  = (a_min == 8'd0 || q_big) ? 8'd255 : quo_nx[7:0];
    prod  = {8'd0, norm} * OMEGA_W;
    haze  = 8'(prod >> 8);
    t_raw = 8'd255 - haze;
    t_new = (t_raw < T0_L) ? T0_L : t_raw;
  end

  // Saturating J = A +/- q; q may exceed 8 bits when t is small
  always_comb begin
    sum   = {1'b0, a_c} + {1'b0, quo_nx[7:0]};
    j_new = 8'd0;
    if (neg) begin
      if (q_big || quo_nx[7:0] > a_c) j_new = 8'd0;
      else                            j_new = a_c - quo_nx[7:0];
    end else begin
      if (q_big || sum[8]) j_new = 8'd255;
      else                 j_new = sum[7:0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sh_r_q <= 8'd255; sh_g_q <= 8'd255; sh_b_q <= 8'd255;
      ar_q <= 8'd0; ag_q <= 8'd0; ab_q <= 8'd0;
      pr_q <= 8'd0; pg_q <= 8'd0; pb_q <= 8'd0;
      dark_q <= 8'd0; last_q <= 1'b0;
      t_q <= 8'd0; jr_q <= 8'd0; jg_q <= 8'd0;
      cnt_q <= 5'd0; rem_q <= 8'd0; dvs_q <= 8'd0; quo_q <= 16'd0;
      out_r <= 8'd0; out_g <= 8'd0; out_b <= 8'd0; out_t <= 8'd0; out_last <= 1'b0;
    end else begin
      if (a_load) begin
        sh_r_q <= a_r; sh_g_q <= a_g; sh_b_q <= a_b;
      end
      if (accept) begin
        ar_q   <= a_load ? a_r : sh_r_q;
        ag_q   <= a_load ? a_g : sh_g_q;
        ab_q   <= a_load ? a_b : sh_b_q;
        pr_q   <= in_r; pg_q <= in_g; pb_q <= in_b;
        dark_q <= in_dark;
        last_q <= in_last;
      end
      if (in_div) begin
        cnt_q <= div_last ? 5'd0 : cnt_q + 5'd1;
        if (cnt_q == 5'd0) begin
          rem_q <= 8'd0;
          quo_q <= dividend;
          dvs_q <= divisor;
        end else begin
          rem_q <= rem_nx;
          quo_q <= quo_nx;
        end
      end else begin
        cnt_q <= 5'd0;
      end
      if (div_last) begin
        case (state_q)
          S_DIV_T: t_q  <= t_new;
          S_DIV_R: jr_q <= j_new;
          S_DIV_G: jg_q <= j_new;
          S_DIV_B: begin
            out_r    <= jr_q;
            out_g    <= jg_q;
            out_b    <= j_new;
            out_t    <= t_q;
            out_last <= last_q;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_scene_recover.sv
// Randomized scoreboard bench for scene_recover against an arithmetic reference model.
module tb_scene_recover;

  localparam int OMEGA = 243;
  localparam int TMIN  = 26;
  localparam int LAT   = 68;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       a_load = 1'b0;
  logic [7:0] a_r = 8'd0, a_g = 8'd0, a_b = 8'd0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_r = 8'd0, in_g = 8'd0, in_b = 8'd0, in_dark = 8'd0;
  logic       in_last = 1'b0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] out_r, out_g, out_b, out_t;
  logic       out_last;

  scene_recover dut (
    .clk(clk), .reset(reset), .a_load(a_load), .a_r(a_r), .a_g(a_g), .a_b(a_b),
    .in_valid(in_valid), .in_ready(in_ready), .in_r(in_r), .in_g(in_g), .in_b(in_b),
    .in_dark(in_dark), .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready),
    .out_r(out_r), .out_g(out_g), .out_b(out_b), .out_t(out_t), .out_last(out_last)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int r; int g; int b; int t; int last; int acc; } exp_t;
  exp_t sb[$];

  int errors = 0;
  int checks = 0;
  int ma_r = 255, ma_g = 255, ma_b = 255;
  bit bp_req = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int recover(input int a, input int i, input int t);
    int d, q, j;
    d = i - a;
    q = ((d < 0) ? -d : d) * 255 / t;
    j = (d >= 0) ? a + q : a - q;
    if (j > 255) j = 255;
    if (j < 0) j = 0;
    return j;
  endfunction

  function automatic exp_t model(input int ar, ag, ab, ir, ig, ib, dk, lst);
    exp_t e;
    int amin, norm, haze, t;
    amin = ar;
    if (ag < amin) amin = ag;
    if (ab < amin) amin = ab;
    if (amin == 0) norm = 255;
    else begin
      norm = dk * 255 / amin;
      if (norm > 255) norm = 255;
    end
    haze = norm * OMEGA / 256;
    t = 255 - haze;
    if (t < TMIN) t = TMIN;
    e.r = recover(ar, ir, t);
    e.g = recover(ag, ig, t);
    e.b = recover(ab, ib, t);
    e.t = t;
    e.last = lst;
    e.acc = 0;
    return e;
  endfunction

  // Monitor: pops on the first cycle a result is presented, then applies backpressure
  bit   presenting = 1'b0;
  bit   post_chk = 1'b0;
  int   hold = 0;
  exp_t snap;

  always @(negedge clk) begin
    if (reset) begin
      presenting = 1'b0;
      post_chk   = 1'b0;
      hold       = 0;
      out_ready  = 1'b0;
    end else begin
      if (post_chk) begin
        chk("post_hs_out_valid", int'(out_valid), 0);
        chk("post_hs_in_ready", int'(in_ready), 1);
        post_chk = 1'b0;
      end
      if (out_valid) begin
        if (!presenting) begin
          if (sb.size() == 0) begin
            chk("unexpected_output", 1, 0);
          end else begin
            exp_t e;
            e = sb.pop_front();
            chk("out_r", int'(out_r), e.r);
            chk("out_g", int'(out_g), e.g);
            chk("out_b", int'(out_b), e.b);
            chk("out_t", int'(out_t), e.t);
            chk("out_last", int'(out_last), e.last);
            chk("latency", cyc - e.acc, LAT);
          end
          presenting = 1'b1;
          hold = bp_req ? 10 : int'($urandom_range(0, 2));
          bp_req = 1'b0;
          snap.r = out_r; snap.g = out_g; snap.b = out_b; snap.t = out_t; snap.last = out_last;
        end else begin
          chk("hold_r", int'(out_r), snap.r);
          chk("hold_g", int'(out_g), snap.g);
          chk("hold_b", int'(out_b), snap.b);
          chk("hold_t", int'(out_t), snap.t);
          chk("hold_last", int'(out_last), snap.last);
          chk("hold_in_ready", int'(in_ready), 0);
        end
        if (hold > 0) begin
          out_ready = 1'b0;
          hold--;
        end else begin
          out_ready  = 1'b1;
          presenting = 1'b0;
          post_chk   = 1'b1;
        end
      end else begin
        out_ready = 1'b0;
      end
    end
  end

  task automatic load_a(input int r, g, b);
    @(negedge clk);
    a_load = 1'b1; a_r = 8'(r); a_g = 8'(g); a_b = 8'(b);
    ma_r = r; ma_g = g; ma_b = b;
    @(negedge clk);
    a_load = 1'b0;
  endtask

  task automatic send(input int ir, ig, ib, dk, lst, input bit ld, input int lr, lg, lb);
    int w;
    exp_t e;
    w = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_r = 8'(ir); in_g = 8'(ig); in_b = 8'(ib); in_dark = 8'(dk); in_last = lst[0];
    while (!in_ready && w < 400) begin
      @(negedge clk);
      w++;
    end
    if (!in_ready) begin
      chk("accept_timeout", 0, 1);
      in_valid = 1'b0;
      return;
    end
    if (ld) begin
      a_load = 1'b1; a_r = 8'(lr); a_g = 8'(lg); a_b = 8'(lb);
      ma_r = lr; ma_g = lg; ma_b = lb;
    end
    e = model(ma_r, ma_g, ma_b, ir, ig, ib, dk, lst);
    @(posedge clk);
    #1;
    e.acc = cyc;
    sb.push_back(e);
    in_valid = 1'b0;
    a_load   = 1'b0;
  endtask

  initial begin
    int w;
    repeat (3) @(negedge clk);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_in_ready", int'(in_ready), 0);
    chk("rst_out_r", int'(out_r), 0);
    chk("rst_out_t", int'(out_t), 0);
    reset = 1'b0;
    #1;
    chk("rst_release_in_ready", int'(in_ready), 1);

    // Directed cases
    load_a(200, 200, 200);
    send(100, 150, 250, 0, 1, 1'b0, 0, 0, 0);
    load_a(200, 180, 220);
    send(210, 170, 230, 180, 0, 1'b0, 0, 0, 0);
    load_a(0, 50, 50);
    send(0, 60, 40, 10, 1, 1'b0, 0, 0, 0);
    bp_req = 1'b1;
    send(30, 220, 90, 40, 0, 1'b1, 120, 130, 140);
    load_a(200, 200, 200);
    send(50, 50, 50, 0, 0, 1'b1, 100, 100, 100);

    // Reset in flight: drop the pixel, A returns to all-255
    send(10, 20, 30, 50, 1, 1'b0, 0, 0, 0);
    repeat (30) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    chk("mid_rst_out_valid", int'(out_valid), 0);
    chk("mid_rst_in_ready", int'(in_ready), 0);
    chk("mid_rst_out_r", int'(out_r), 0);
    chk("mid_rst_out_g", int'(out_g), 0);
    chk("mid_rst_out_b", int'(out_b), 0);
    chk("mid_rst_out_t", int'(out_t), 0);
    chk("mid_rst_out_last", int'(out_last), 0);
    sb.delete();
    ma_r = 255; ma_g = 255; ma_b = 255;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("mid_rst_release_in_ready", int'(in_ready), 1);
    send(100, 50, 200, 100, 1, 1'b0, 0, 0, 0);

    // Random traffic with occasional A reloads, some on the acceptance edge
    for (int k = 0; k < 24; k++) begin
      int sel;
      sel = int'($urandom_range(0, 3));
      if (sel == 0)
        load_a(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
      send(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
           int'($urandom_range(0, 255)), int'($urandom_range(0, 1)), (sel == 1),
           int'($urandom_range(1, 255)), int'($urandom_range(1, 255)), int'($urandom_range(1, 255)));
    end

    w = 0;
    while ((sb.size() != 0 || presenting || post_chk) && w < 3000) begin
      @(negedge clk);
      w++;
    end
    if (sb.size() != 0 || presenting) chk("drain_timeout", sb.size(), 0);
    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
